// File: rtl/mult_issue_pkg.sv
// Shared types and constants for the multiplier issue controller.
package mult_issue_pkg;

  localparam int ARG_W          = 16;
  localparam int RES_W          = 32;
  localparam int TMO_W          = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_TIMEOUT    = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RES = 2'd2
  } issue_state_t;

  typedef struct packed {
    logic [ARG_W-1:0] arg_a;
    logic [ARG_W-1:0] arg_b;
    logic [1:0]       inj_err;
  } operand_entry_t;

  // Even parity of an operand, optionally inverted to inject an error.
  function automatic logic arg_parity(input logic [ARG_W-1:0] arg, input logic inj);
    return (^arg) ^ inj;
  endfunction

endpackage

// File: rtl/mult_issue_ctrl_if.sv
// Operand stream, multiplier handshake and result stream of the issue controller.
interface mult_issue_ctrl_if;
  import mult_issue_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [ARG_W-1:0] in_arg_a;
  logic [ARG_W-1:0] in_arg_b;
  logic [1:0]       in_inj_err;

  logic [ARG_W-1:0] mult_arg_a;
  logic             mult_arg_a_parity;
  logic [ARG_W-1:0] mult_arg_b;
  logic             mult_arg_b_parity;
  logic             mult_req;
  logic             mult_ack;
  logic [RES_W-1:0] mult_result;
  logic             mult_result_parity;
  logic             mult_result_rdy;
  logic             mult_arg_parity_error;

  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_result;
  logic             out_arg_err;
  logic             out_res_par_err;
  logic             out_timeout;

  // Controller side.
  modport master (
    input  in_valid, in_arg_a, in_arg_b, in_inj_err,
    input  mult_ack, mult_result, mult_result_parity, mult_result_rdy, mult_arg_parity_error,
    input  out_ready,
    output in_ready,
    output mult_arg_a, mult_arg_a_parity, mult_arg_b, mult_arg_b_parity, mult_req,
    output out_valid, out_result, out_arg_err, out_res_par_err, out_timeout
  );

  // Environment side (producer, multiplier and consumer).
  modport slave (
    output in_valid, in_arg_a, in_arg_b, in_inj_err,
    output mult_ack, mult_result, mult_result_parity, mult_result_rdy, mult_arg_parity_error,
    output out_ready,
    input  in_ready,
    input  mult_arg_a, mult_arg_a_parity, mult_arg_b, mult_arg_b_parity, mult_req,
    input  out_valid, out_result, out_arg_err, out_res_par_err, out_timeout
  );

endinterface

// File: rtl/mult_issue_fifo.sv
// Small synchronous FIFO of operand entries; depth must be a power of two.
module mult_issue_fifo
  import mult_issue_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  operand_entry_t           wr_data,
  output operand_entry_t           rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  operand_entry_t mem_q [DEPTH];
  operand_entry_t mem_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW:0]    count_q, count_d;
  logic           do_push_s, do_pop_s;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == {(PW+1){1'b0}});
  assign count     = count_q;
  assign rd_data   = mem_q[rd_ptr_q];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Next-state for storage, pointers (wrap naturally) and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + {{PW{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{PW{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {(PW+1){1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue stage for the signed multiplier: buffers operands, runs the req/ack
// handshake one operation at a time and returns results in order with
// parity and watchdog status.
module mult_issue_ctrl
  import mult_issue_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  mult_issue_ctrl_if.master bus,
  output logic              busy
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  issue_state_t     state_q, state_d;
  logic [ARG_W-1:0] arg_a_q, arg_a_d, arg_b_q, arg_b_d;
  logic             par_a_q, par_a_d, par_b_q, par_b_d;
  logic             req_q, req_d;
  logic             pend_q, pend_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [RES_W-1:0] out_result_q, out_result_d;
  logic             out_arg_err_q, out_arg_err_d;
  logic             out_res_par_err_q, out_res_par_err_d;
  logic             out_timeout_q, out_timeout_d;

  logic             fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0] fifo_count_s;
  operand_entry_t   fifo_wr_s, fifo_rd_s;
  logic             slot_free_s;

  assign fifo_wr_s   = '{arg_a: bus.in_arg_a, arg_b: bus.in_arg_b, inj_err: bus.in_inj_err};
  assign fifo_push_s = bus.in_valid & ~fifo_full_s;
  assign slot_free_s = ~out_valid_q | bus.out_ready;

  mult_issue_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push_s),
    .pop     (fifo_pop_s),
    .wr_data (fifo_wr_s),
    .rd_data (fifo_rd_s),
    .count   (fifo_count_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Issue FSM: pop into the argument registers, track the multiplier
  // handshake and fill the output register on result or watchdog abort.
  always_comb begin
    state_d           = state_q;
    arg_a_d           = arg_a_q;
    arg_b_d           = arg_b_q;
    par_a_d           = par_a_q;
    par_b_d           = par_b_q;
    req_d             = req_q;
    tmo_cnt_d         = tmo_cnt_q;
    out_result_d      = out_result_q;
    out_arg_err_d     = out_arg_err_q;
    out_res_par_err_d = out_res_par_err_q;
    out_timeout_d     = out_timeout_q;
    fifo_pop_s        = 1'b0;
    // Entries become issuable one cycle after they land, so an accepted
    // operand always spends a full cycle in the FIFO.
    pend_d            = (fifo_count_s != {CNT_W{1'b0}});
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    case (state_q)
      IDLE: begin
        if (pend_q && !fifo_empty_s && slot_free_s) begin
          fifo_pop_s = 1'b1;
          arg_a_d    = fifo_rd_s.arg_a;
          arg_b_d    = fifo_rd_s.arg_b;
          par_a_d    = arg_parity(fifo_rd_s.arg_a, fifo_rd_s.inj_err[0]);
          par_b_d    = arg_parity(fifo_rd_s.arg_b, fifo_rd_s.inj_err[1]);
          req_d      = 1'b1;
          tmo_cnt_d  = {TMO_W{1'b0}};
          state_d    = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.mult_ack) begin
          req_d     = 1'b0;
          tmo_cnt_d = {TMO_W{1'b0}};
          state_d   = WAIT_RES;
        end else if (tmo_cnt_q == TMO_LAST) begin
          req_d             = 1'b0;
          out_valid_d       = 1'b1;
          out_result_d      = {RES_W{1'b0}};
          out_arg_err_d     = 1'b0;
          out_res_par_err_d = 1'b0;
          out_timeout_d     = 1'b1;
          state_d           = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      WAIT_RES: begin
        if (bus.mult_result_rdy) begin
          out_valid_d       = 1'b1;
          out_result_d      = bus.mult_result;
          out_arg_err_d     = bus.mult_arg_parity_error;
          out_res_par_err_d = ((^bus.mult_result) ^ bus.mult_result_parity) & ~bus.mult_arg_parity_error;
          out_timeout_d     = 1'b0;
          state_d           = IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          out_valid_d       = 1'b1;
          out_result_d      = {RES_W{1'b0}};
          out_arg_err_d     = 1'b0;
          out_res_par_err_d = 1'b0;
          out_timeout_d     = 1'b1;
          state_d           = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Controller registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      arg_a_q           <= {ARG_W{1'b0}};
      arg_b_q           <= {ARG_W{1'b0}};
      par_a_q           <= 1'b0;
      par_b_q           <= 1'b0;
      req_q             <= 1'b0;
      pend_q            <= 1'b0;
      tmo_cnt_q         <= {TMO_W{1'b0}};
      out_valid_q       <= 1'b0;
      out_result_q      <= {RES_W{1'b0}};
      out_arg_err_q     <= 1'b0;
      out_res_par_err_q <= 1'b0;
      out_timeout_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      arg_a_q           <= arg_a_d;
      arg_b_q           <= arg_b_d;
      par_a_q           <= par_a_d;
      par_b_q           <= par_b_d;
      req_q             <= req_d;
      pend_q            <= pend_d;
      tmo_cnt_q         <= tmo_cnt_d;
      out_valid_q       <= out_valid_d;
      out_result_q      <= out_result_d;
      out_arg_err_q     <= out_arg_err_d;
      out_res_par_err_q <= out_res_par_err_d;
      out_timeout_q     <= out_timeout_d;
    end
  end

  assign bus.in_ready          = ~fifo_full_s;
  assign bus.mult_arg_a        = arg_a_q;
  assign bus.mult_arg_b        = arg_b_q;
  assign bus.mult_arg_a_parity = par_a_q;
  assign bus.mult_arg_b_parity = par_b_q;
  assign bus.mult_req          = req_q;
  assign bus.out_valid         = out_valid_q;
  assign bus.out_result        = out_result_q;
  assign bus.out_arg_err       = out_arg_err_q;
  assign bus.out_res_par_err   = out_res_par_err_q;
  assign bus.out_timeout       = out_timeout_q;
  assign busy                  = (state_q != IDLE) | ~fifo_empty_s;

endmodule
